// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width, line level
// and the baud divisor helper used by both uart_tx and the future uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   UART_DATA_W = 8;
  localparam logic LINE_IDLE   = 1'b1;

  function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: emits a one-cycle tick every CLKS_PER_BIT cycles and
// realigns to zero whenever restart is asserted.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (restart || (count_reg == LAST)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, 8N1 or 8N2, LSB first, all outputs registered.
// Define UART_PARITY_EN to insert an even parity bit after data bit 7.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_RATE  = 100_000_000,
  parameter int BAUD_RATE = 3_000_000,
  parameter int STOP_BITS = 1
) (
  input  logic                   CLK_I,
  input  logic                   RST_NI,
  input  logic [UART_DATA_W-1:0] DATA_I,
  input  logic                   WRITE_I,
  output logic                   TX_READY_O,
  output logic                   TX_O
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx: CLK_RATE/BAUD_RATE must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  tx_state_t              state_reg;
  logic [UART_DATA_W-1:0] shift_reg;
  logic [2:0]             bit_idx_reg;
  logic                   stop_cnt_reg;
  logic                   tx_reg;
  logic                   ready_reg;
  logic                   accept;
  logic                   bit_tick;
`ifdef UART_PARITY_EN
  logic                   parity_reg;
`endif

  // Only sampled while ready, so a WRITE_I held past acceptance is ignored.
  assign accept = ready_reg && WRITE_I;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (CLK_I),
    .rst_n  (RST_NI),
    .restart(accept),
    .tick   (bit_tick)
  );

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= LINE_IDLE;
      ready_reg    <= 1'b0;
`ifdef UART_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shift_reg    <= DATA_I;
            bit_idx_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            tx_reg       <= 1'b0;
            ready_reg    <= 1'b0;
            state_reg    <= START;
`ifdef UART_PARITY_EN
            parity_reg   <= ^DATA_I;
`endif
          end else begin
            tx_reg    <= LINE_IDLE;
            ready_reg <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            tx_reg    <= shift_reg[0];
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_reg    <= parity_reg;
              state_reg <= PARITY;
`else
              tx_reg    <= LINE_IDLE;
              state_reg <= STOP;
`endif
            end else begin
              // Next bit comes from position 1 because the shift lands this edge.
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            tx_reg    <= LINE_IDLE;
            state_reg <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (stop_cnt_reg == 1'(STOP_BITS - 1)) begin
              ready_reg <= 1'b1;
              state_reg <= IDLE;
            end else begin
              stop_cnt_reg <= 1'b1;
            end
          end
        end
        default: begin
          tx_reg    <= LINE_IDLE;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign TX_O       = tx_reg;
  assign TX_READY_O = ready_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at CLKS_PER_BIT=10: one-stop and two-stop instances,
// mid-bit line decoding, ready timing, held writes, back-to-back and mid-frame reset.
module tb_uart_tx;

  localparam int CPB = 10;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] data1  = 8'h00;
  logic [7:0] data2  = 8'h00;
  logic       write1 = 1'b0;
  logic       write2 = 1'b0;
  logic       ready1, tx1, ready2, tx2;
  logic       sel    = 1'b0;
  logic       tx_mon, ready_mon;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.CLK_RATE(100), .BAUD_RATE(10), .STOP_BITS(1)) dut (
    .CLK_I(clk), .RST_NI(rst_n), .DATA_I(data1), .WRITE_I(write1),
    .TX_READY_O(ready1), .TX_O(tx1)
  );

  uart_tx #(.CLK_RATE(100), .BAUD_RATE(10), .STOP_BITS(2)) dut2 (
    .CLK_I(clk), .RST_NI(rst_n), .DATA_I(data2), .WRITE_I(write2),
    .TX_READY_O(ready2), .TX_O(tx2)
  );

  assign tx_mon    = sel ? tx2 : tx1;
  assign ready_mon = sel ? ready2 : ready1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] d);
    if (sel) begin write2 = w; data2 = d; end
    else begin write1 = w; data1 = d; end
  endtask

  // Waits for ready, writes d and returns just after the accept edge (frame cycle 0).
  task automatic start_write(input logic [7:0] d);
    int n = 0;
    while (ready_mon !== 1'b1 && n < 300) begin tick(); n++; end
    if (ready_mon !== 1'b1) begin
      check_cnt++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready_mon, n);
    end
    drive(1'b1, d);
    exp_q.push_back(d);
    tick();
  endtask

  // Samples the line mid-bit from frame cycle 0 until ready rises (bounded).
  task automatic rx_frame(input int nstop, input bit hold, input logic [7:0] hold_data,
                          input bit chain, input logic [7:0] chain_data,
                          output logic [7:0] data, output logic start_b,
                          output logic par_b, output logic stop_ok, output int rise);
    int   f = (10 + nstop - 1 + PAR) * CPB;
    logic bits [0:11];
    for (int i = 0; i < 12; i++) bits[i] = 1'bx;
    rise = -1;
    if (hold) drive(1'b1, hold_data);
    else drive(1'b0, 8'h00);
    for (int cyc = 1; cyc <= f + 20; cyc++) begin
      tick();
      if (cyc == 1) drive(1'b0, 8'h00);
      if ((cyc % CPB == CPB / 2) && (cyc / CPB < 12)) bits[cyc / CPB] = tx_mon;
      if (ready_mon === 1'b1) begin
        rise = cyc;
        if (chain) drive(1'b1, chain_data);
        break;
      end
    end
    start_b = bits[0];
    for (int i = 0; i < 8; i++) data[i] = bits[i + 1];
    par_b   = bits[9];
    stop_ok = 1'b1;
    for (int s = 0; s < nstop; s++) if (bits[9 + PAR + s] !== 1'b1) stop_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_cnt++; if (tx1 !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx1); else pass_cnt++;
    check_cnt++; if (ready1 !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready1); else pass_cnt++;
    check_cnt++; if (tx2 !== 1'b1) $display("FAIL reset_tx2: got %b want 1", tx2); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    check_cnt++; if (ready1 !== 1'b0) $display("FAIL release_ready_early: got %b want 0", ready1); else pass_cnt++;
    tick();
    check_cnt++; if (ready1 !== 1'b1) $display("FAIL release_ready: got %b want 1", ready1); else pass_cnt++;
    $display("reset: tx=%b ready=%b", tx1, ready1);
  endtask

  task automatic test_basic(input logic [7:0] d);
    logic [7:0] got, exp;
    logic st, pb, sp;
    int rise;
    start_write(d);
    check_cnt++; if (tx_mon !== 1'b0) $display("FAIL basic_start_edge: tx=%b want 0", tx_mon); else pass_cnt++;
    rx_frame(1, 1'b0, 8'h00, 1'b0, 8'h00, got, st, pb, sp, rise);
    exp = exp_q.pop_front();
    check_cnt++; if (st !== 1'b0) $display("FAIL basic_start: got %b want 0", st); else pass_cnt++;
    check_cnt++; if (got !== exp) $display("FAIL basic_data: got %h want %h", got, exp); else pass_cnt++;
    check_cnt++; if (sp !== 1'b1) $display("FAIL basic_stop: got %b want 1", sp); else pass_cnt++;
    check_cnt++; if (rise != (10 + PAR) * CPB) $display("FAIL basic_ready_rise: got %0d want %0d", rise, (10 + PAR) * CPB); else pass_cnt++;
    $display("frame: sent %h decoded %h ready_rise=%0d", exp, got, rise);
  endtask

  task automatic test_hold_write();
    logic [7:0] got, exp;
    logic st, pb, sp;
    int rise, bad;
    start_write(8'h3C);
    rx_frame(1, 1'b1, 8'hFF, 1'b0, 8'h00, got, st, pb, sp, rise);
    exp = exp_q.pop_front();
    check_cnt++; if (got !== exp) $display("FAIL hold_data: got %h want %h", got, exp); else pass_cnt++;
    check_cnt++; if (rise != (10 + PAR) * CPB) $display("FAIL hold_ready_rise: got %0d want %0d", rise, (10 + PAR) * CPB); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tx_mon !== 1'b1 || ready_mon !== 1'b1) bad++;
    end
    check_cnt++; if (bad != 0) $display("FAIL hold_second_frame: %0d busy cycles want 0", bad); else pass_cnt++;
    $display("hold: sent %h decoded %h, idle after frame busy_cycles=%0d", exp, got, bad);
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    logic st, pb, sp;
    int rise;
    start_write(8'hB1);
    rx_frame(1, 1'b0, 8'h00, 1'b1, 8'h42, got, st, pb, sp, rise);
    exp_q.push_back(8'h42);
    exp = exp_q.pop_front();
    check_cnt++; if (got !== exp) $display("FAIL b2b_data0: got %h want %h", got, exp); else pass_cnt++;
    check_cnt++; if (rise != (10 + PAR) * CPB) $display("FAIL b2b_ready_low0: low %0d want %0d", rise - 1, (10 + PAR) * CPB - 1); else pass_cnt++;
    check_cnt++; if (tx_mon !== 1'b1) $display("FAIL b2b_gap_line: tx=%b want 1", tx_mon); else pass_cnt++;
    $display("b2b: sent %h decoded %h ready_rise=%0d", exp, got, rise);
    tick();
    check_cnt++; if (tx_mon !== 1'b0 || ready_mon !== 1'b0) $display("FAIL b2b_accept: tx=%b ready=%b want 0 0", tx_mon, ready_mon); else pass_cnt++;
    rx_frame(1, 1'b0, 8'h00, 1'b0, 8'h00, got, st, pb, sp, rise);
    exp = exp_q.pop_front();
    check_cnt++; if (got !== exp) $display("FAIL b2b_data1: got %h want %h", got, exp); else pass_cnt++;
    check_cnt++; if (rise != (10 + PAR) * CPB) $display("FAIL b2b_ready_low1: low %0d want %0d", rise - 1, (10 + PAR) * CPB - 1); else pass_cnt++;
    $display("b2b: sent %h decoded %h ready_rise=%0d", exp, got, rise);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp;
    start_write(8'h00);
    for (int i = 0; i < 37; i++) tick();
    check_cnt++; if (tx1 !== 1'b0) $display("FAIL midrst_before: tx=%b want 0", tx1); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    check_cnt++; if (tx1 !== 1'b1) $display("FAIL midrst_async_tx: tx=%b want 1", tx1); else pass_cnt++;
    check_cnt++; if (ready1 !== 1'b0) $display("FAIL midrst_ready: got %b want 0", ready1); else pass_cnt++;
    exp = exp_q.pop_front();
    tick();
    rst_n = 1'b1;
    #1;
    check_cnt++; if (ready1 !== 1'b0) $display("FAIL midrst_ready_release: got %b want 0", ready1); else pass_cnt++;
    tick();
    check_cnt++; if (ready1 !== 1'b1 || tx1 !== 1'b1) $display("FAIL midrst_recover: ready=%b tx=%b want 1 1", ready1, tx1); else pass_cnt++;
    $display("midrst: frame %h abandoned, tx=%b ready=%b", exp, tx1, ready1);
    test_basic(8'h81);
  endtask

  task automatic test_two_stop();
    logic [7:0] got, exp;
    logic st, pb, sp;
    int rise;
    sel = 1'b1;
    start_write(8'h00);
    rx_frame(2, 1'b0, 8'h00, 1'b0, 8'h00, got, st, pb, sp, rise);
    exp = exp_q.pop_front();
    check_cnt++; if (got !== exp) $display("FAIL stop2_data: got %h want %h", got, exp); else pass_cnt++;
    check_cnt++; if (sp !== 1'b1) $display("FAIL stop2_stop: got %b want 1", sp); else pass_cnt++;
    check_cnt++; if (rise != (11 + PAR) * CPB) $display("FAIL stop2_ready_rise: got %0d want %0d", rise, (11 + PAR) * CPB); else pass_cnt++;
    $display("stop2: sent %h decoded %h ready_rise=%0d", exp, got, rise);
    sel = 1'b0;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity(input logic [7:0] d);
    logic [7:0] got, exp;
    logic st, pb, sp;
    int rise;
    start_write(d);
    rx_frame(1, 1'b0, 8'h00, 1'b0, 8'h00, got, st, pb, sp, rise);
    exp = exp_q.pop_front();
    check_cnt++; if (got !== exp) $display("FAIL parity_data: got %h want %h", got, exp); else pass_cnt++;
    check_cnt++; if (pb !== ^exp) $display("FAIL parity_bit: got %b want %b", pb, ^exp); else pass_cnt++;
    check_cnt++; if (rise != 11 * CPB) $display("FAIL parity_ready_rise: got %0d want %0d", rise, 11 * CPB); else pass_cnt++;
    $display("parity: sent %h decoded %h parity=%b ready_rise=%0d", exp, got, pb, rise);
  endtask
`endif

  initial begin
    test_reset();
    test_basic(8'hA5);
    test_hold_write();
    test_back_to_back();
    test_reset_mid_frame();
    test_two_stop();
`ifdef UART_PARITY_EN
    test_parity(8'h07);
    test_parity(8'h03);
`endif
    check_cnt++; if (exp_q.size() != 0) $display("FAIL scoreboard_empty: %0d left want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
